// File: rtl/red_pitaya_xadc_drp_ctrl.sv
// red_pitaya_xadc_drp_ctrl: XADC DRP sequencer and arbiter.
// EOC-triggered result reads always win over software DRP accesses.
module red_pitaya_xadc_drp_ctrl #(
    parameter int TMO = 255
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        eoc_i,
    input  logic [4:0]  channel_i,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    input  logic        sw_req_i,
    input  logic        sw_we_i,
    input  logic [6:0]  sw_addr_i,
    input  logic [15:0] sw_wdata_i,
    output logic        sw_busy_o,
    output logic        sw_ack_o,
    output logic        sw_err_o,
    output logic [15:0] sw_rdata_o,
    output logic        smp_vld_o,
    output logic [4:0]  smp_ch_o,
    output logic [11:0] smp_dat_o,
    output logic [15:0] ovr_cnt_o
);

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        AUTO_WAIT = 2'd1,
        SW_WAIT   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        auto_pend_q, auto_pend_d;
    logic [4:0]  auto_ch_q, auto_ch_d;
    logic        sw_pend_q, sw_pend_d;
    logic        sw_we_q, sw_we_d;
    logic [6:0]  sw_addr_q, sw_addr_d;
    logic [15:0] sw_wdata_q, sw_wdata_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        is_auto_q, is_auto_d;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        sw_ack_q, sw_ack_d;
    logic        sw_err_q, sw_err_d;
    logic [15:0] sw_rdata_q, sw_rdata_d;
    logic        smp_vld_q, smp_vld_d;
    logic [4:0]  smp_ch_q, smp_ch_d;
    logic [11:0] smp_dat_q, smp_dat_d;
    logic [15:0] ovr_cnt_q, ovr_cnt_d;
    logic [1:0]  ovr_inc;
    logic [16:0] ovr_sum;
    logic        in_wait;
    logic        tmo_hit;

    assign in_wait = (state_q != IDLE);
    assign tmo_hit = in_wait && !drp_drdy_i && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            auto_pend_q <= 1'b0;
            auto_ch_q   <= '0;
            sw_pend_q   <= 1'b0;
            sw_we_q     <= 1'b0;
            sw_addr_q   <= '0;
            sw_wdata_q  <= '0;
            tmo_cnt_q   <= '0;
            is_auto_q   <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
            sw_ack_q    <= 1'b0;
            sw_err_q    <= 1'b0;
            sw_rdata_q  <= '0;
            smp_vld_q   <= 1'b0;
            smp_ch_q    <= '0;
            smp_dat_q   <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            auto_pend_q <= auto_pend_d;
            auto_ch_q   <= auto_ch_d;
            sw_pend_q   <= sw_pend_d;
            sw_we_q     <= sw_we_d;
            sw_addr_q   <= sw_addr_d;
            sw_wdata_q  <= sw_wdata_d;
            tmo_cnt_q   <= tmo_cnt_d;
            is_auto_q   <= is_auto_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            sw_ack_q    <= sw_ack_d;
            sw_err_q    <= sw_err_d;
            sw_rdata_q  <= sw_rdata_d;
            smp_vld_q   <= smp_vld_d;
            smp_ch_q    <= smp_ch_d;
            smp_dat_q   <= smp_dat_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    // den_q marks the issue cycle; the FSM is still IDLE while it is high
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (den_q) state_d = is_auto_q ? AUTO_WAIT : SW_WAIT;
            end
            AUTO_WAIT, SW_WAIT: begin
                if (drp_drdy_i || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        auto_pend_d = auto_pend_q;
        auto_ch_d   = auto_ch_q;
        sw_pend_d   = sw_pend_q;
        sw_we_d     = sw_we_q;
        sw_addr_d   = sw_addr_q;
        sw_wdata_d  = sw_wdata_q;
        is_auto_d   = is_auto_q;
        den_d       = 1'b0;
        dwe_d       = dwe_q;
        daddr_d     = daddr_q;
        di_d        = di_q;
        sw_ack_d    = 1'b0;
        sw_err_d    = 1'b0;
        sw_rdata_d  = sw_rdata_q;
        smp_vld_d   = 1'b0;
        smp_ch_d    = smp_ch_q;
        smp_dat_d   = smp_dat_q;
        ovr_inc     = 2'd0;

        if (den_q) tmo_cnt_d = '0;
        else if (in_wait && !drp_drdy_i) tmo_cnt_d = tmo_cnt_q + 8'd1;
        else tmo_cnt_d = tmo_cnt_q;

        if (eoc_i) begin
            auto_pend_d = 1'b1;
            auto_ch_d   = channel_i;
            if (auto_pend_q && !(den_q && is_auto_q)) ovr_inc = ovr_inc + 2'd1;
        end else if (den_q && is_auto_q) begin
            auto_pend_d = 1'b0;
        end

        if (sw_req_i && !sw_pend_q) begin
            sw_pend_d  = 1'b1;
            sw_we_d    = sw_we_i;
            sw_addr_d  = sw_addr_i;
            sw_wdata_d = sw_wdata_i;
        end

        if (state_q == AUTO_WAIT) begin
            if (drp_drdy_i) begin
                smp_vld_d = 1'b1;
                smp_ch_d  = daddr_q[4:0];
                smp_dat_d = drp_do_i[15:4];
            end else if (tmo_hit) begin
                ovr_inc = ovr_inc + 2'd1;
            end
        end

        if (state_q == SW_WAIT && (drp_drdy_i || tmo_hit)) begin
            sw_ack_d  = 1'b1;
            sw_pend_d = 1'b0;
            if (tmo_hit) begin
                sw_err_d   = 1'b1;
                sw_rdata_d = '0;
            end else if (!sw_we_q) begin
                sw_rdata_d = drp_do_i;
            end
        end

        if (state_d == IDLE && (auto_pend_d || sw_pend_d)) begin
            den_d     = 1'b1;
            is_auto_d = auto_pend_d;
            if (auto_pend_d) begin
                dwe_d   = 1'b0;
                daddr_d = {2'b00, auto_ch_d};
            end else begin
                dwe_d   = sw_we_d;
                daddr_d = sw_addr_d;
                di_d    = sw_wdata_d;
            end
        end

        ovr_sum   = {1'b0, ovr_cnt_q} + 17'(ovr_inc);
        ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
    end

    assign drp_den_o   = den_q;
    assign drp_dwe_o   = dwe_q;
    assign drp_daddr_o = daddr_q;
    assign drp_di_o    = di_q;
    assign sw_busy_o   = sw_pend_q;
    assign sw_ack_o    = sw_ack_q;
    assign sw_err_o    = sw_err_q;
    assign sw_rdata_o  = sw_rdata_q;
    assign smp_vld_o   = smp_vld_q;
    assign smp_ch_o    = smp_ch_q;
    assign smp_dat_o   = smp_dat_q;
    assign ovr_cnt_o   = ovr_cnt_q;

endmodule

// File: tb/tb_red_pitaya_xadc_drp_ctrl.sv
// Bench for red_pitaya_xadc_drp_ctrl: directed scenarios plus random
// traffic against a transaction-level model with a random DRP slave.
module tb_red_pitaya_xadc_drp_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        eoc_i = 1'b0;
    logic [4:0]  channel_i = '0;
    logic        drp_den_o, drp_dwe_o;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic [15:0] drp_do_i = '0;
    logic        drp_drdy_i = 1'b0;
    logic        sw_req_i = 1'b0;
    logic        sw_we_i = 1'b0;
    logic [6:0]  sw_addr_i = '0;
    logic [15:0] sw_wdata_i = '0;
    logic        sw_busy_o, sw_ack_o, sw_err_o;
    logic [15:0] sw_rdata_o;
    logic        smp_vld_o;
    logic [4:0]  smp_ch_o;
    logic [11:0] smp_dat_o;
    logic [15:0] ovr_cnt_o;

    int checks = 0;
    int failures = 0;

    red_pitaya_xadc_drp_ctrl #(.TMO(TMO)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .eoc_i(eoc_i), .channel_i(channel_i),
        .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o),
        .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o),
        .drp_do_i(drp_do_i), .drp_drdy_i(drp_drdy_i),
        .sw_req_i(sw_req_i), .sw_we_i(sw_we_i),
        .sw_addr_i(sw_addr_i), .sw_wdata_i(sw_wdata_i),
        .sw_busy_o(sw_busy_o), .sw_ack_o(sw_ack_o),
        .sw_err_o(sw_err_o), .sw_rdata_o(sw_rdata_o),
        .smp_vld_o(smp_vld_o), .smp_ch_o(smp_ch_o),
        .smp_dat_o(smp_dat_o), .ovr_cnt_o(ovr_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic lit(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    // Transaction-level model: expected outputs for the coming cycle.
    logic        e_den = 0, e_dwe = 0, e_busy = 0, e_ack = 0, e_err = 0, e_vld = 0;
    logic [6:0]  e_addr = 0;
    logic [15:0] e_di = 0, e_rdata = 0, e_ovr = 0;
    logic [4:0]  e_ch = 0;
    logic [11:0] e_dat = 0;
    bit          m_apend = 0, m_busy = 0, m_queued = 0, m_we = 0;
    logic [4:0]  m_ach = 0, m_ich = 0;
    logic [6:0]  m_addr = 0;
    logic [15:0] m_wd = 0;
    int          m_out = 0;
    int          m_iss = 0;
    int          mcyc = 0;
    bit          chk_en = 0;

    task automatic model_step();
        int c;
        int add;
        c = mcyc;
        mcyc++;
        add = 0;
        if (!rstn_i) begin
            e_den = 0; e_dwe = 0; e_busy = 0; e_ack = 0; e_err = 0; e_vld = 0;
            e_addr = 0; e_di = 0; e_rdata = 0; e_ovr = 0; e_ch = 0; e_dat = 0;
            m_apend = 0; m_busy = 0; m_queued = 0; m_out = 0;
            chk_en = 1;
            return;
        end
        e_den = 0; e_ack = 0; e_err = 0; e_vld = 0;
        if (m_out != 0 && c > m_iss) begin
            if (drp_drdy_i) begin
                if (m_out == 1) begin
                    e_vld = 1; e_ch = m_ich; e_dat = drp_do_i[15:4];
                end else begin
                    e_ack = 1; m_busy = 0;
                    if (!m_we) e_rdata = drp_do_i;
                end
                m_out = 0;
            end else if (c - m_iss == TMO) begin
                if (m_out == 1) add++;
                else begin
                    e_ack = 1; e_err = 1; e_rdata = 0; m_busy = 0;
                end
                m_out = 0;
            end
        end
        if (eoc_i) begin
            if (m_apend) add++;
            m_apend = 1; m_ach = channel_i;
        end
        if (sw_req_i && !e_busy) begin
            m_busy = 1; m_queued = 1;
            m_we = sw_we_i; m_addr = sw_addr_i; m_wd = sw_wdata_i;
        end
        if (m_out == 0) begin
            if (m_apend) begin
                e_den = 1; e_dwe = 0; e_addr = {2'b00, m_ach};
                m_ich = m_ach; m_apend = 0; m_out = 1; m_iss = c + 1;
            end else if (m_queued) begin
                e_den = 1; e_dwe = m_we; e_addr = m_addr; e_di = m_wd;
                m_queued = 0; m_out = 2; m_iss = c + 1;
            end
        end
        e_ovr = (int'(e_ovr) + add > 65535) ? 16'hFFFF : 16'(int'(e_ovr) + add);
        e_busy = m_busy;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    always @(negedge clk) begin
        if (chk_en) begin
            lit("den", 32'(drp_den_o), 32'(e_den));
            lit("dwe", 32'(drp_dwe_o), 32'(e_dwe));
            lit("daddr", 32'(drp_daddr_o), 32'(e_addr));
            lit("di", 32'(drp_di_o), 32'(e_di));
            lit("busy", 32'(sw_busy_o), 32'(e_busy));
            lit("ack", 32'(sw_ack_o), 32'(e_ack));
            lit("err", 32'(sw_err_o), 32'(e_err));
            lit("rdata", 32'(sw_rdata_o), 32'(e_rdata));
            lit("vld", 32'(smp_vld_o), 32'(e_vld));
            lit("smp_ch", 32'(smp_ch_o), 32'(e_ch));
            lit("smp_dat", 32'(smp_dat_o), 32'(e_dat));
            lit("ovr", 32'(ovr_cnt_o), 32'(e_ovr));
        end
    end

    logic [15:0] mem [128];
    int          s_cnt = 0;
    bit          s_we = 0;
    logic [6:0]  s_addr = 0;

    task automatic cyc();
        @(posedge clk);
        #1;
        eoc_i = 0;
        sw_req_i = 0;
        drp_drdy_i = 0;
        drp_do_i = 16'($urandom);
    endtask

    task automatic slave_step();
        if (s_cnt > 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
                drp_drdy_i = 1;
                drp_do_i = s_we ? 16'($urandom) : mem[s_addr];
            end
        end else if ($urandom_range(0, 29) == 0) begin
            drp_drdy_i = 1;
        end
        if (drp_den_o) begin
            if (drp_dwe_o) mem[drp_daddr_o] = drp_di_o;
            s_we = drp_dwe_o;
            s_addr = drp_daddr_o;
            s_cnt = $urandom_range(1, 10);
        end
    endtask

    task automatic sw(input bit we, input logic [6:0] a, input logic [15:0] d);
        sw_req_i = 1; sw_we_i = we; sw_addr_i = a; sw_wdata_i = d;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        cyc();
        cyc();
        lit("rst_den", 32'(drp_den_o), 32'd0);
        lit("rst_busy", 32'(sw_busy_o), 32'd0);
        lit("rst_rdata", 32'(sw_rdata_o), 32'd0);
        lit("rst_ovr", 32'(ovr_cnt_o), 32'd0);
        rstn_i = 1;

        // auto read
        cyc(); eoc_i = 1; channel_i = 5'd16;
        cyc();
        lit("a_den", 32'(drp_den_o), 32'd1);
        lit("a_addr", 32'(drp_daddr_o), 32'h10);
        lit("a_dwe", 32'(drp_dwe_o), 32'd0);
        cyc(); cyc(); cyc(); drp_drdy_i = 1; drp_do_i = 16'hABC0;
        cyc();
        lit("a_vld", 32'(smp_vld_o), 32'd1);
        lit("a_ch", 32'(smp_ch_o), 32'd16);
        lit("a_dat", 32'(smp_dat_o), 32'hABC);

        // software write then read
        cyc(); sw(1, 7'h50, 16'hB5ED);
        cyc();
        lit("w_busy", 32'(sw_busy_o), 32'd1);
        lit("w_den", 32'(drp_den_o), 32'd1);
        lit("w_dwe", 32'(drp_dwe_o), 32'd1);
        lit("w_di", 32'(drp_di_o), 32'hB5ED);
        cyc(); drp_drdy_i = 1;
        cyc();
        lit("w_ack", 32'(sw_ack_o), 32'd1);
        lit("w_err", 32'(sw_err_o), 32'd0);
        sw(0, 7'h50, 16'h0);
        cyc();
        lit("r_den", 32'(drp_den_o), 32'd1);
        lit("r_dwe", 32'(drp_dwe_o), 32'd0);
        cyc(); drp_drdy_i = 1; drp_do_i = 16'hB5ED;
        cyc();
        lit("r_ack", 32'(sw_ack_o), 32'd1);
        lit("r_err", 32'(sw_err_o), 32'd0);
        lit("r_rdata", 32'(sw_rdata_o), 32'hB5ED);

        // arbitration
        cyc(); eoc_i = 1; channel_i = 5'd3; sw(0, 7'h20, 16'h0);
        cyc();
        lit("arb_addr", 32'(drp_daddr_o), 32'h03);
        lit("arb_busy", 32'(sw_busy_o), 32'd1);
        cyc(); drp_drdy_i = 1; drp_do_i = 16'h1230;
        cyc();
        lit("arb_vld", 32'(smp_vld_o), 32'd1);
        lit("arb_swden", 32'(drp_den_o), 32'd1);
        lit("arb_swaddr", 32'(drp_daddr_o), 32'h20);
        lit("arb_busy2", 32'(sw_busy_o), 32'd1);
        cyc(); drp_drdy_i = 1; drp_do_i = 16'h7777;
        cyc();
        lit("arb_ack", 32'(sw_ack_o), 32'd1);
        lit("arb_rdata", 32'(sw_rdata_o), 32'h7777);

        // overrun
        cyc(); eoc_i = 1; channel_i = 5'd5;
        cyc();
        cyc(); eoc_i = 1; channel_i = 5'd1;
        cyc(); eoc_i = 1; channel_i = 5'd2;
        cyc();
        lit("ovr_1", 32'(ovr_cnt_o), 32'd1);
        drp_drdy_i = 1; drp_do_i = 16'h5550;
        cyc();
        lit("ovr_ch5", 32'(smp_ch_o), 32'd5);
        lit("ovr_den", 32'(drp_den_o), 32'd1);
        lit("ovr_addr", 32'(drp_daddr_o), 32'h02);
        cyc(); drp_drdy_i = 1;
        cyc();
        lit("ovr_ch2", 32'(smp_ch_o), 32'd2);

        // timeouts
        cyc(); sw(0, 7'h11, 16'h0);
        cyc();
        lit("to_den", 32'(drp_den_o), 32'd1);
        for (int k = 0; k < TMO; k++) begin
            cyc();
            lit("to_noack", 32'(sw_ack_o), 32'd0);
        end
        cyc();
        lit("to_ack", 32'(sw_ack_o), 32'd1);
        lit("to_err", 32'(sw_err_o), 32'd1);
        lit("to_rdata", 32'(sw_rdata_o), 32'd0);
        cyc(); eoc_i = 1; channel_i = 5'd7;
        cyc();
        lit("ato_addr", 32'(drp_daddr_o), 32'h07);
        for (int k = 0; k < TMO + 1; k++) begin
            cyc();
            lit("ato_novld", 32'(smp_vld_o), 32'd0);
        end
        lit("ato_ovr", 32'(ovr_cnt_o), 32'd2);

        // reset mid-transfer
        cyc(); sw(0, 7'h22, 16'h0);
        cyc();
        cyc(); rstn_i = 0;
        cyc();
        lit("rm_busy", 32'(sw_busy_o), 32'd0);
        lit("rm_ovr", 32'(ovr_cnt_o), 32'd0);
        lit("rm_ch", 32'(smp_ch_o), 32'd0);
        lit("rm_dat", 32'(smp_dat_o), 32'd0);
        rstn_i = 1;
        cyc(); drp_drdy_i = 1; drp_do_i = 16'hFFFF;
        cyc();
        lit("rm_ack", 32'(sw_ack_o), 32'd0);
        lit("rm_vld", 32'(smp_vld_o), 32'd0);
        lit("rm_busy2", 32'(sw_busy_o), 32'd0);
        lit("rm_rdata", 32'(sw_rdata_o), 32'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            cyc();
            rstn_i = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 9) == 0) begin
                eoc_i = 1;
                channel_i = 5'($urandom);
            end
            if ($urandom_range(0, 4) == 0)
                sw(1'($urandom), 7'($urandom), 16'($urandom));
            slave_step();
        end
        rstn_i = 1;
        for (int n = 0; n < 30; n++) begin
            cyc();
            slave_step();
        end
        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
